m_dm: RTL and testbench
=======================

// Module: M_dm
// PURPOSE
//  Data memory for the M stage, with store-side byte/halfword alignment and byte-enable writes.
//  - Inputs: the M-stage address, raw rt store data and a store op code.
//  - Read path is combinational. Rdata is the raw aligned word; M_data_ext slices and extends it downstream.
//  - Array spans byte addresses 0x0000 .. 4*DEPTH-1.
// PARAMETERS
//  DEPTH   3072  number of 32-bit words in the array
//  AW      12    word-index width; DEPTH <= 2**AW
// PORTS
//  clk     in   1   system clock, rising edge active
//  reset   in   1   asynchronous, active-high reset
//  PC      in   32  PC of the M-stage instruction (write log only)
//  A       in   32  byte address from ALU result
//  WD      in   32  unaligned store data (rt value, low-justified)
//  StOp    in   2   00 none, 01 sw, 10 sh, 11 sb
//  Rdata   out  32  word at index A[AW+1:2]; 0 if out of range
//  BE      out  4   byte enables applied this cycle
//  Misalign out 1   registered: last store was misaligned
// BEHAVIOUR
//  Reset (async, active-high):
//   - all DEPTH words cleared to 0; Misalign <= 0.
//   - Rdata therefore reads 0 while reset is asserted and after release.
//  Index: idx = A[AW+1:2]; in_range = (A[31:AW+2] == 0) && (idx < DEPTH).
//  Byte enables (combinational; BE = 0 when StOp = 00 or !in_range):
//   - sw: 4'b1111.
//   - sh: A[1] ? 4'b1100 : 4'b0011.
//   - sb: 4'b0001 << A[1:0].
//  Aligned write data:
//   - sw: WD.
//   - sh: {2{WD[15:0]}}.
//   - sb: {4{WD[7:0]}}.
//  Write: at posedge clk, when !reset, every byte k with BE[k] = 1 takes the aligned byte k. Other bytes hold.
//  Misalignment: sw with A[1:0] != 0, or sh with A[0] = 1.
//   - The store is suppressed (BE forced to 0).
//   - Misalign <= 1 at that posedge. Any other cycle sets Misalign <= 0.
//  Read:
//   - Rdata = mem[idx], combinational, with no write-through forwarding.
//   - A store in cycle N is visible to a load issued in cycle N+1. A same-cycle read returns the old value.
//  Simultaneous events:
//   - Reset asserted at a clock edge with a pending store: the clear wins; the store is lost.
//   - Reset released mid-cycle: the first write takes effect at the next posedge.
//  Address wrap: none. Out-of-range stores are dropped silently (BE = 0). Out-of-range reads return 0.
// CONFIGURATION
//  DM_WRITE_LOG_EN defined:
//   - On every committed write, $display("%d@%h: *%h <= %h", $time, PC, {A[31:2],2'b00}, merged_word).
//   - merged_word is the full 32-bit word after the byte merge.
//   - No output for suppressed (misaligned or out-of-range) writes.
//  Not defined: no simulation output; the logic is otherwise identical.
// STRUCTURE
//  Shared package/header (defines used by the D-stage controller):
//   - StOp codes ST_NONE/ST_W/ST_H/ST_B.
//   - The load-op codes consumed by M_data_ext (LD_W=000, LD_BU=001, LD_B=010, LD_HU=011, LD_H=100).
//  One sub-module, M_st_align: purely combinational; (A[1:0], WD, StOp) -> (BE, aligned data, misaligned).
//   - This keeps the array and reset loop in M_dm small.
// TESTING
//  1. Reset then read: assert reset, release, read A=0x0000 and A=0x2ffc -> Rdata=0 for both.
//  2. sw then lw: sw A=0x10 WD=0x12345678; next cycle Rdata@0x10=0x12345678, BE during store=1111.
//  3. Byte merge: sw 0x10=0x12345678, then sb A=0x13 WD=0x000000AB -> word 0xAB345678, BE=1000.
//     - Then sh A=0x10 WD=0xFFFFCDEF -> word 0xAB34CDEF, BE=0011.
//  4. Misalign: sw A=0x22 WD=0xDEADBEEF -> BE=0, mem[0x20] unchanged, Misalign=1 next cycle, 0 after.
//     - Then sh A=0x21 gives the same result.
//  5. Range: sw A=0x3000 WD=1 -> BE=0, no write; Rdata@0x3000=0; Rdata@0x0000 unaffected.
//  6. Reset mid-operation: store 0x55 to 0x40, then assert reset with sw 0x40=0x99 pending at the edge.
//     - Expect Rdata@0x40=0 after release.
//     - With DM_WRITE_LOG_EN, the log shows only the first write.

Source files
------------

// File: rtl/m_dm_pkg.sv
// Shared definitions for the M-stage data memory: store/load op codes and the byte-merge helper.
package m_dm_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_W    = 2'b01,
        ST_H    = 2'b10,
        ST_B    = 2'b11
    } st_op_e;

    // Load codes are consumed by the data-extension stage, not by the memory itself
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BU = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_H  = 3'b100
    } ld_op_e;

    localparam int DM_DEPTH = 3072;
    localparam int DM_AW    = 12;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int k = 0; k < 4; k++) begin
            result[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/m_dm_st_align.sv
// Store-side alignment: maps (byte offset, raw store data, store op) to byte enables,
// replicated write data and a misalignment flag. Purely combinational.
module m_dm_st_align
    import m_dm_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [31:0] wd,
    input  st_op_e      stop,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Misaligned word/half stores are suppressed here by forcing their enables to zero
    always_comb begin
        be         = 4'b0000;
        wdata      = wd;
        misaligned = 1'b0;
        case (stop)
            ST_W: begin
                misaligned = (offset != 2'b00);
                be         = misaligned ? 4'b0000 : 4'b1111;
            end
            ST_H: begin
                misaligned = offset[0];
                wdata      = {2{wd[15:0]}};
                be         = misaligned ? 4'b0000 : (offset[1] ? 4'b1100 : 4'b0011);
            end
            ST_B: begin
                wdata = {4{wd[7:0]}};
                be    = 4'b0001 << offset;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/m_dm.sv
// M-stage data memory: combinational word read, byte-enable writes, async clear.
// Optional write log to the simulator console is enabled by defining DM_WRITE_LOG_EN.
module m_dm
    import m_dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [1:0]  StOp,
    output logic [31:0] Rdata,
    output logic [3:0]  BE,
    output logic        Misalign
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          in_range;
    logic [3:0]    be_raw;
    logic [31:0]   wdata;
    logic          misaligned;
    logic [31:0]   merged_word;

    assign idx      = A[AW+1:2];
    assign in_range = (A[31:AW+2] == '0) && (32'(idx) < DEPTH);

    m_dm_st_align u_align (
        .offset     (A[1:0]),
        .wd         (WD),
        .stop       (st_op_e'(StOp)),
        .be         (be_raw),
        .wdata      (wdata),
        .misaligned (misaligned)
    );

    // Out-of-range stores are dropped by gating the enables; out-of-range reads see zero
    assign BE          = in_range ? be_raw : 4'b0000;
    assign Rdata       = in_range ? mem[idx] : 32'h0;
    assign merged_word = merge_bytes(Rdata, wdata, BE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            Misalign <= 1'b0;
        end else begin
            if (BE != 4'b0000) begin
                mem[idx] <= merged_word;
            end
            Misalign <= misaligned;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always @(posedge clk) begin
        if (!reset && BE != 4'b0000) begin
            $display("%d@%h: *%h <= %h", $time, PC, {A[31:2], 2'b00}, merged_word);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_m_dm.sv
// Directed bench for m_dm: expectations are queued as stimulus is applied and
// popped as the corresponding DUT output is sampled.
module tb_m_dm;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] A;
    logic [31:0] WD;
    logic [1:0]  StOp;
    logic [31:0] Rdata;
    logic [3:0]  BE;
    logic        Misalign;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];
    int   tests;
    int   failures;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SW   = 2'b01;
    localparam logic [1:0] OP_SH   = 2'b10;
    localparam logic [1:0] OP_SB   = 2'b11;

    m_dm dut (
        .clk      (clk),
        .reset    (reset),
        .PC       (PC),
        .A        (A),
        .WD       (WD),
        .StOp     (StOp),
        .Rdata    (Rdata),
        .BE       (BE),
        .Misalign (Misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] op);
        A    = addr;
        WD   = data;
        StOp = op;
        PC   = 32'h0000_3000 + addr;
        #1;
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        tests++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed %h required an entry", observed);
        end else begin
            e = expQ.pop_front();
            assert (observed === e.value) else begin
                failures++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(32'h0, 32'h0, OP_NONE);
        tick();
        tick();
        pushExpect("rdata_in_reset", 32'h0);
        checkOutput(Rdata);
        reset = 1'b0;
        tick();

        pushExpect("rdata_0_after_reset", 32'h0);
        checkOutput(Rdata);
        pushExpect("misalign_after_reset", 32'h0);
        checkOutput({31'b0, Misalign});
        applyStimulus(32'h2ffc, 32'h0, OP_NONE);
        pushExpect("rdata_top_after_reset", 32'h0);
        checkOutput(Rdata);

        applyStimulus(32'h10, 32'h1234_5678, OP_SW);
        pushExpect("be_sw", 32'hF);
        checkOutput({28'b0, BE});
        pushExpect("rdata_same_cycle_old", 32'h0);
        checkOutput(Rdata);
        tick();
        applyStimulus(32'h10, 32'h0, OP_NONE);
        pushExpect("rdata_after_sw", 32'h1234_5678);
        checkOutput(Rdata);

        applyStimulus(32'h13, 32'h0000_00AB, OP_SB);
        pushExpect("be_sb_3", 32'h8);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h10, 32'hFFFF_CDEF, OP_SH);
        pushExpect("rdata_after_sb", 32'hAB34_5678);
        checkOutput(Rdata);
        pushExpect("be_sh_lo", 32'h3);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h12, 32'h0000_1111, OP_SH);
        pushExpect("rdata_after_sh_lo", 32'hAB34_CDEF);
        checkOutput(Rdata);
        pushExpect("be_sh_hi", 32'hC);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h11, 32'h0000_0022, OP_SB);
        pushExpect("rdata_after_sh_hi", 32'h1111_CDEF);
        checkOutput(Rdata);
        pushExpect("be_sb_1", 32'h2);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h10, 32'h0, OP_NONE);
        pushExpect("rdata_after_sb_1", 32'h1111_22EF);
        checkOutput(Rdata);

        applyStimulus(32'h20, 32'h0BAD_F00D, OP_SW);
        tick();
        applyStimulus(32'h22, 32'hDEAD_BEEF, OP_SW);
        pushExpect("be_sw_misaligned", 32'h0);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h20, 32'h0, OP_NONE);
        pushExpect("misalign_sw_set", 32'h1);
        checkOutput({31'b0, Misalign});
        pushExpect("rdata_sw_suppressed", 32'h0BAD_F00D);
        checkOutput(Rdata);
        tick();
        pushExpect("misalign_sw_clear", 32'h0);
        checkOutput({31'b0, Misalign});
        applyStimulus(32'h21, 32'hDEAD_BEEF, OP_SH);
        pushExpect("be_sh_misaligned", 32'h0);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h20, 32'h0, OP_NONE);
        pushExpect("misalign_sh_set", 32'h1);
        checkOutput({31'b0, Misalign});
        pushExpect("rdata_sh_suppressed", 32'h0BAD_F00D);
        checkOutput(Rdata);
        tick();
        pushExpect("misalign_sh_clear", 32'h0);
        checkOutput({31'b0, Misalign});

        applyStimulus(32'h3000, 32'h1, OP_SW);
        pushExpect("be_out_of_range", 32'h0);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h3000, 32'h0, OP_NONE);
        pushExpect("rdata_out_of_range", 32'h0);
        checkOutput(Rdata);
        pushExpect("misalign_out_of_range", 32'h0);
        checkOutput({31'b0, Misalign});
        applyStimulus(32'h0, 32'h0, OP_NONE);
        pushExpect("rdata_0_unaffected", 32'h0);
        checkOutput(Rdata);
        applyStimulus(32'h0001_0010, 32'h0, OP_NONE);
        pushExpect("rdata_high_bits_no_alias", 32'h0);
        checkOutput(Rdata);
        applyStimulus(32'h2ffc, 32'hCAFE_F00D, OP_SW);
        pushExpect("be_top_word", 32'hF);
        checkOutput({28'b0, BE});
        tick();
        applyStimulus(32'h2ffc, 32'h0, OP_NONE);
        pushExpect("rdata_top_word", 32'hCAFE_F00D);
        checkOutput(Rdata);

        applyStimulus(32'h40, 32'h55, OP_SW);
        tick();
        applyStimulus(32'h40, 32'h0, OP_NONE);
        pushExpect("rdata_before_reset", 32'h55);
        checkOutput(Rdata);
        applyStimulus(32'h40, 32'h99, OP_SW);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(32'h40, 32'h0, OP_NONE);
        tick();
        pushExpect("rdata_store_lost_in_reset", 32'h0);
        checkOutput(Rdata);
        applyStimulus(32'h10, 32'h0, OP_NONE);
        pushExpect("rdata_cleared_by_reset", 32'h0);
        checkOutput(Rdata);
        applyStimulus(32'h44, 32'h7777_0000, OP_SW);
        tick();
        applyStimulus(32'h44, 32'h0, OP_NONE);
        pushExpect("rdata_write_after_release", 32'h7777_0000);
        checkOutput(Rdata);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
